// File: rtl/mem_ctrl_responder_pkg.sv
// Shared memory-interface types: command layout, beat count and the
// responder FSM state encoding.
package libmemif;

    localparam int MEMRESP_ADDR_W = 10;
    localparam int MEMRESP_BEATS  = 2;

    typedef struct packed {
        logic [MEMRESP_ADDR_W-1:0] addr;
        logic                      wr;
    } mem_resp_cmd_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } memresp_state_e;

endpackage

// File: rtl/mem_ctrl_responder_fifo.sv
// First-word-fall-through synchronous FIFO with a registered almost-full flag
// and a sticky flag for pushes while full or pops while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SLACK = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             almost_full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d, empty_q, empty_d, ovf_q, ovf_d;
    logic             push_ok_s, pop_ok_s;

    // Next-state: pointer/count update, flags and protocol-error accumulation.
    always_comb begin
        push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
        pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == {CNT_W{1'b0}});
        // Derived from the current count, so the flag trails the count by a cycle.
        afull_d = (count_q >= CNT_W'(DEPTH - SLACK));
        ovf_d   = ovf_q | (push_i & ~push_ok_s) | (pop_i & ~pop_ok_s);
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o        = empty_q ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign almost_full_o = afull_q;
    assign empty_o       = empty_q;
    assign overflow_o    = ovf_q;

endmodule

// File: rtl/mem_ctrl_responder.sv
// Memory-side endpoint: queues address commands and write beats, services
// them serially against an on-chip line store, and returns read beats via rb.
module mem_ctrl_responder
    import libmemif::*;
#(
    parameter int ADDR_W   = MEMRESP_ADDR_W,
    parameter int DATA_W   = 144,
    parameter int BEATS    = MEMRESP_BEATS,
    parameter int AF_DEPTH = 16,
    parameter int WB_DEPTH = 32,
    parameter int RB_DEPTH = 16,
    parameter int SLACK    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              af_we,
    input  logic [ADDR_W-1:0] af_addr,
    input  logic              af_wr,
    output logic              af_full,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_full,
    input  logic              rb_re,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_empty,
    output logic              ovf_err
);

    // BEATS is expected to be at least 2; beat 0 is issued on the IDLE pop.
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = ADDR_W + BEAT_W;
    localparam int AF_CW  = $clog2(AF_DEPTH) + 1;
    localparam int WB_CW  = $clog2(WB_DEPTH) + 1;
    localparam int RB_CW  = $clog2(RB_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    logic [ADDR_W:0]     af_head_s;
    logic [AF_CW-1:0]    af_cnt_s;
    logic                af_empty_s, af_pop_s, af_ovf_s;
    logic [DATA_W-1:0]   wb_head_s;
    logic [WB_CW-1:0]    wb_cnt_s;
    logic                wb_empty_s, wb_pop_s, wb_ovf_s;
    logic [RB_CW-1:0]    rb_cnt_s;
    logic                rb_afull_s, rb_ovf_s;
    logic                rb_room_s, wb_ready_s, rd_en_s, wr_en_s;
    logic [IDX_W-1:0]    store_idx_s;
    logic                unused_ok_s;

    memresp_state_e      state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   store_q [2**IDX_W];

    sync_fifo_fwft #(.WIDTH(ADDR_W + 1), .DEPTH(AF_DEPTH), .SLACK(SLACK)) u_af (
        .clk_i(clk), .rst_ni(rst), .push_i(af_we), .data_i({af_addr, af_wr}),
        .pop_i(af_pop_s), .data_o(af_head_s), .count_o(af_cnt_s),
        .almost_full_o(af_full), .empty_o(af_empty_s), .overflow_o(af_ovf_s)
    );

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(WB_DEPTH), .SLACK(SLACK)) u_wb (
        .clk_i(clk), .rst_ni(rst), .push_i(wb_we), .data_i(wb_data),
        .pop_i(wb_pop_s), .data_o(wb_head_s), .count_o(wb_cnt_s),
        .almost_full_o(wb_full), .empty_o(wb_empty_s), .overflow_o(wb_ovf_s)
    );

    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(RB_DEPTH), .SLACK(SLACK)) u_rb (
        .clk_i(clk), .rst_ni(rst), .push_i(rd_valid_q), .data_i(rd_data_q),
        .pop_i(rb_re), .data_o(rb_data), .count_o(rb_cnt_s),
        .almost_full_o(rb_afull_s), .empty_o(rb_empty), .overflow_o(rb_ovf_s)
    );

    // A read may start only if rb can absorb a whole line plus the beat still in flight.
    assign rb_room_s  = (32'(rb_cnt_s) + 32'(rd_valid_q) + 32'(BEATS)) <= 32'(RB_DEPTH);
    assign wb_ready_s = 32'(wb_cnt_s) >= 32'(BEATS);
    assign ovf_err    = af_ovf_s | wb_ovf_s | rb_ovf_s;
    assign unused_ok_s = ^{af_cnt_s, rb_afull_s};

    // FSM next-state, FIFO pops and store port control.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        af_pop_s    = 1'b0;
        wb_pop_s    = 1'b0;
        rd_en_s     = 1'b0;
        wr_en_s     = 1'b0;
        store_idx_s = {addr_q, beat_q};
        case (state_q)
            ST_IDLE: begin
                if (!af_empty_s && !af_head_s[0] && rb_room_s) begin
                    af_pop_s    = 1'b1;
                    rd_en_s     = 1'b1;
                    store_idx_s = {af_head_s[ADDR_W:1], {BEAT_W{1'b0}}};
                    addr_d      = af_head_s[ADDR_W:1];
                    beat_d      = BEAT_W'(1);
                    state_d     = ST_RD;
                end else if (!af_empty_s && af_head_s[0] && wb_ready_s) begin
                    af_pop_s = 1'b1;
                    addr_d   = af_head_s[ADDR_W:1];
                    beat_d   = {BEAT_W{1'b0}};
                    state_d  = ST_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                rd_en_s = 1'b1;
                if (beat_q == BEAT_LAST) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_WR: begin
                wr_en_s  = !wb_empty_s;
                wb_pop_s = !wb_empty_s;
                if (wb_empty_s) begin
                    state_d = ST_WR;
                end else if (beat_q == BEAT_LAST) begin
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and read-valid pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            beat_q     <= {BEAT_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            rd_valid_q <= rd_en_s;
        end
    end

    // Line store with registered read port; never cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            store_q[store_idx_s] <= wb_head_s;
        end
        if (rd_en_s) begin
            rd_data_q <= store_q[store_idx_s];
        end
    end

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// Directed self-checking bench for mem_ctrl_responder.
module tb_mem_ctrl_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         af_we = 1'b0;
    logic [9:0]   af_addr = 10'h000;
    logic         af_wr = 1'b0;
    logic         af_full;
    logic         wb_we = 1'b0;
    logic [143:0] wb_data = 144'h0;
    logic         wb_full;
    logic         rb_re = 1'b0;
    logic [143:0] rb_data;
    logic         rb_empty;
    logic         ovf_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl_responder dut (
        .clk(clk), .rst(rst),
        .af_we(af_we), .af_addr(af_addr), .af_wr(af_wr), .af_full(af_full),
        .wb_we(wb_we), .wb_data(wb_data), .wb_full(wb_full),
        .rb_re(rb_re), .rb_data(rb_data), .rb_empty(rb_empty), .ovf_err(ovf_err)
    );

    function automatic logic [143:0] pat(input logic [9:0] a, input logic b);
        pat = {16'hC0DE, 6'b000000, a, 7'b0000000, b, 104'h0123456789ABCDEF0011223344};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [9:0] a, input logic wr);
        af_addr = a; af_wr = wr; af_we = 1'b1;
        step();
        af_we = 1'b0;
    endtask

    task automatic write_line(input logic [9:0] a, input logic [143:0] d0, input logic [143:0] d1);
        af_addr = a; af_wr = 1'b1; af_we = 1'b1; wb_data = d0; wb_we = 1'b1;
        step();
        af_we = 1'b0; wb_data = d1;
        step();
        wb_we = 1'b0;
    endtask

    task automatic pop_beat(output logic [143:0] d, output bit ok);
        ok = 1'b0;
        d = 144'h0;
        for (int n = 0; n < 300; n++) begin
            if (!rb_empty) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) begin
            d = rb_data;
            rb_re = 1'b1;
            step();
            rb_re = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #3;
        checks++; if (af_full !== 1'b0) begin failures++; $display("FAIL reset_af_full: got %b expected 0", af_full); end
        checks++; if (wb_full !== 1'b0) begin failures++; $display("FAIL reset_wb_full: got %b expected 0", wb_full); end
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL reset_rb_empty: got %b expected 1", rb_empty); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
        checks++; if (rb_data !== 144'h0) begin failures++; $display("FAIL reset_rb_data: got %h expected 0", rb_data); end
        step(); step();
        @(negedge clk) rst = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        logic [143:0] d;
        bit ok;
        write_line(10'h005, pat(10'h005, 1'b0), pat(10'h005, 1'b1));
        push_cmd(10'h005, 1'b0);
        for (int b = 0; b < 2; b++) begin
            pop_beat(d, ok);
            checks++;
            if (!ok || d !== pat(10'h005, 1'(b))) begin
                failures++;
                $display("FAIL wr_rd_beat%0d: got %h (ok=%0d) expected %h", b, d, ok, pat(10'h005, 1'(b)));
            end
        end
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL wr_rd_empty_after: got %b expected 1", rb_empty); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL wr_rd_ovf: got %b expected 0", ovf_err); end
    endtask

    task automatic test_read_latency();
        logic [143:0] d;
        bit ok;
        repeat (4) step();
        af_addr = 10'h005; af_wr = 1'b0; af_we = 1'b1;
        step();
        af_we = 1'b0;
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL latency_c1: got %b expected 1", rb_empty); end
        step();
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL latency_c2: got %b expected 1", rb_empty); end
        step();
        checks++; if (rb_empty !== 1'b0) begin failures++; $display("FAIL latency_c3: got %b expected 0", rb_empty); end
        checks++; if (rb_data !== pat(10'h005, 1'b0)) begin failures++; $display("FAIL latency_data: got %h expected %h", rb_data, pat(10'h005, 1'b0)); end
        pop_beat(d, ok);
        pop_beat(d, ok);
        checks++;
        if (!ok || d !== pat(10'h005, 1'b1)) begin
            failures++;
            $display("FAIL latency_beat1: got %h (ok=%0d) expected %h", d, ok, pat(10'h005, 1'b1));
        end
    endtask

    task automatic test_backpressure();
        logic [143:0] d;
        logic [9:0] a;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            a = 10'(10'h3F0 + 10'(i));
            write_line(a, pat(a, 1'b0), pat(a, 1'b1));
        end
        repeat (80) step();
        for (int i = 0; i < 8; i++) begin
            af_addr = 10'(10'h3F0 + 10'(i)); af_wr = 1'b0; af_we = 1'b1;
            step();
        end
        af_we = 1'b0;
        repeat (40) step();
        checks++; if (rb_empty !== 1'b0) begin failures++; $display("FAIL bp_rb_filled: got empty=%b expected 0", rb_empty); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL bp_no_ovf: got %b expected 0", ovf_err); end
        for (int i = 8; i < 20; i++) begin
            af_addr = 10'(10'h3F0 + 10'(i)); af_wr = 1'b0; af_we = 1'b1;
            step();
        end
        af_we = 1'b0;
        checks++; if (af_full !== 1'b0) begin failures++; $display("FAIL bp_af_full_lag: got %b expected 0", af_full); end
        step();
        checks++; if (af_full !== 1'b1) begin failures++; $display("FAIL bp_af_full_at12: got %b expected 1", af_full); end
        for (int i = 0; i < 20; i++) begin
            for (int b = 0; b < 2; b++) begin
                a = 10'(10'h3F0 + 10'(i));
                pop_beat(d, ok);
                checks++;
                if (!ok || d !== pat(a, 1'(b))) begin
                    failures++;
                    $display("FAIL bp_drain_line%0d_beat%0d: got %h (ok=%0d) expected %h", i, b, d, ok, pat(a, 1'(b)));
                end
            end
        end
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL bp_empty_end: got %b expected 1", rb_empty); end
        checks++; if (af_full !== 1'b0) begin failures++; $display("FAIL bp_af_full_end: got %b expected 0", af_full); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL bp_ovf_end: got %b expected 0", ovf_err); end
    endtask

    task automatic test_write_starvation();
        logic [143:0] d;
        bit ok;
        write_line(10'h2A0, pat(10'h2A0, 1'b0), pat(10'h2A0, 1'b1));
        repeat (6) step();
        af_addr = 10'h2A0; af_wr = 1'b1; af_we = 1'b1; wb_data = ~pat(10'h2A0, 1'b0); wb_we = 1'b1;
        step();
        wb_we = 1'b0; af_wr = 1'b0;
        step();
        af_we = 1'b0;
        repeat (10) step();
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL starve_read_blocked: got empty=%b expected 1", rb_empty); end
        wb_data = ~pat(10'h2A0, 1'b1); wb_we = 1'b1;
        step();
        wb_we = 1'b0;
        for (int b = 0; b < 2; b++) begin
            pop_beat(d, ok);
            checks++;
            if (!ok || d !== ~pat(10'h2A0, 1'(b))) begin
                failures++;
                $display("FAIL starve_new_data_beat%0d: got %h (ok=%0d) expected %h", b, d, ok, ~pat(10'h2A0, 1'(b)));
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            af_addr = 10'(i); af_wr = 1'b1; af_we = 1'b1;
            step();
            if (i == 15) begin
                checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_at16: got %b expected 0", ovf_err); end
            end
        end
        af_we = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_at17: got %b expected 1", ovf_err); end
        checks++; if (af_full !== 1'b1) begin failures++; $display("FAIL ovf_af_full: got %b expected 1", af_full); end
        repeat (5) step();
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf_err); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_cleared_by_reset: got %b expected 0", ovf_err); end
        step();
        @(negedge clk) rst = 1'b1;
        step();
        rb_re = 1'b1;
        step();
        rb_re = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_rb_underflow: got %b expected 1", ovf_err); end
        repeat (3) step();
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_underflow_sticky: got %b expected 1", ovf_err); end
    endtask

    task automatic test_reset_mid_rd();
        logic [143:0] d;
        bit ok;
        push_cmd(10'h005, 1'b0);
        step();
        step();
        checks++; if (rb_empty !== 1'b0) begin failures++; $display("FAIL midrd_beat0_present: got empty=%b expected 0", rb_empty); end
        checks++; if (rb_data !== pat(10'h005, 1'b0)) begin failures++; $display("FAIL midrd_beat0_data: got %h expected %h", rb_data, pat(10'h005, 1'b0)); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL midrd_rb_empty: got %b expected 1", rb_empty); end
        checks++; if (rb_data !== 144'h0) begin failures++; $display("FAIL midrd_rb_data: got %h expected 0", rb_data); end
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL midrd_ovf: got %b expected 0", ovf_err); end
        checks++; if (af_full !== 1'b0 || wb_full !== 1'b0) begin failures++; $display("FAIL midrd_full_flags: got af=%b wb=%b expected 0 0", af_full, wb_full); end
        step();
        @(negedge clk) rst = 1'b1;
        repeat (6) step();
        checks++; if (rb_empty !== 1'b1) begin failures++; $display("FAIL midrd_aborted: got empty=%b expected 1", rb_empty); end
        push_cmd(10'h005, 1'b0);
        for (int b = 0; b < 2; b++) begin
            pop_beat(d, ok);
            checks++;
            if (!ok || d !== pat(10'h005, 1'(b))) begin
                failures++;
                $display("FAIL midrd_store_kept_beat%0d: got %h (ok=%0d) expected %h", b, d, ok, pat(10'h005, 1'(b)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_latency();
        test_backpressure();
        test_write_starvation();
        test_overflow();
        test_reset_mid_rd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
